gpio_irq_core: RTL and testbench
================================

GPIO_IRQ_CORE -- requirements
Module: gpio_irq_core

Interface
REQ-001 The block SHALL have parameter PIN_NUM, default 32, number of pins; legal range 1..32.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth; legal range 2..4.
REQ-003 The block SHALL have parameter DB_W, default 8, debounce counter and threshold width.
REQ-004 The block SHALL have port clk_i, input, 1 bit, the single clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port rst_i, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port gpio_in_i, input, PIN_NUM bits, raw asynchronous pad inputs.
REQ-007 The block SHALL have port db_en_i, input, PIN_NUM bits, per-pin debounce enable.
REQ-008 The block SHALL have port db_thresh_i, input, DB_W bits, shared debounce threshold T.
REQ-009 The block SHALL have port inten_i, input, PIN_NUM bits, per-pin interrupt enable.
REQ-010 The block SHALL have ports inttype0_i and inttype1_i, input, PIN_NUM bits each, per-pin interrupt type.
REQ-011 The block SHALL have port stat_clr_i, input, PIN_NUM bits, one-cycle write-1-to-clear mask for status.
REQ-012 The block SHALL have port in_o, output, PIN_NUM bits, filtered pin value.
REQ-013 The block SHALL have port stat_o, output, PIN_NUM bits, sticky interrupt status.
REQ-014 The block SHALL have port irq_o, output, 1 bit, combined interrupt request.

Function
REQ-015 Each pin SHALL pass through a SYNC_STAGES-deep flop chain; the chain output is "sync".
REQ-016 With db_en_i[n]=0, filt[n] SHALL register sync[n] every cycle.
REQ-017 With db_en_i[n]=1, a per-pin DB_W-bit counter SHALL increment each cycle sync!=filt, SHALL clear whenever sync==filt, and filt SHALL take sync (counter cleared) on the edge where the counter equals T.
REQ-018 A new level SHALL therefore be accepted only after T+1 consecutive differing cycles; T=0 SHALL behave identically to bypass; the counter SHALL never wrap (T is at most 2^DB_W-1).
REQ-019 Changing db_en_i or db_thresh_i mid-count SHALL take effect the next cycle without corrupting filt.
REQ-020 in_o SHALL equal filt; with SYNC_STAGES=2 and debounce off, a pad change SHALL appear on in_o after 3 rising edges.
REQ-021 filt_q SHALL hold filt delayed one cycle; rise = filt & ~filt_q, fall = ~filt & filt_q.
REQ-022 Event per pin by {inttype1,inttype0}: 00 rising edge, 01 falling edge, 10 high level, 11 low level.
REQ-023 stat[n] SHALL set on the edge after event[n] & inten_i[n], giving status one cycle after in_o changes.
REQ-024 stat[n] SHALL clear on the edge after stat_clr_i[n]=1; simultaneous set and clear SHALL leave stat[n]=1.
REQ-025 Level types SHALL re-set status every cycle the level persists, so clear is ineffective until the level drops.
REQ-026 Clearing inten_i[n] SHALL block new sets but SHALL NOT clear stat[n].
REQ-027 irq_o SHALL equal OR over n of (stat[n] & inten_i[n]), combinational from registers, visible the same cycle as stat_o.
REQ-028 Type changes SHALL NOT generate spurious edge events; edges derive only from filt/filt_q.

Reset
REQ-029 On rst_i=1 at a rising edge, all sync stages, filt, filt_q, counters and stat SHALL become 0, so in_o=0, stat_o=0, irq_o=0.
REQ-030 A pin held high through reset SHALL produce a rising edge after release, which is the required behaviour.
REQ-031 Reset asserted mid-debounce SHALL abandon the count with no status update.

Structure
REQ-032 Package gpio_pkg SHALL hold the 2-bit interrupt-type enum (RISE, FALL, HIGH, LOW) and the default PIN_NUM, SYNC_STAGES and DB_W constants.
REQ-033 Sub-module gpio_debounce SHALL implement the synchroniser, debounce and filt for one pin, generated PIN_NUM times.
REQ-034 Edge, status and irq logic SHALL be in gpio_irq_core itself.

Verification
REQ-035 Scenario 1: debounce off, type RISE, inten[0]=1, pin0 0->1 -> in_o[0]=1 at edge 3, stat_o[0]=1 and irq_o=1 at edge 4; stat_clr_i[0] pulse -> stat_o[0]=0 at the next edge.
REQ-036 Scenario 2: db_en[1]=1, T=3, pin1 pulses high for 3 cycles -> in_o[1] stays 0; high for 4 cycles -> in_o[1]=1.
REQ-037 Scenario 3: type HIGH, pin2 held high, stat_clr_i[2] pulsed -> stat_o[2] stays 1; pin low then clear -> stat_o[2]=0.
REQ-038 Scenario 4: falling event and stat_clr_i on the same pin in the same cycle -> stat_o stays 1.
REQ-039 Scenario 5: inten=0 while edges toggle -> stat_o=0 and irq_o=0; set stat, then drop inten -> stat_o=1, irq_o=0.
REQ-040 Scenario 6: rst_i asserted mid-debounce with pin high at release -> all outputs 0, then a rising event after release.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared types and default sizing for the GPIO interrupt core.
package gpio_pkg;

  localparam int unsigned DefaultPinNum     = 32;
  localparam int unsigned DefaultSyncStages = 2;
  localparam int unsigned DefaultDbW        = 8;

  // Encoding is {inttype1, inttype0}
  typedef enum logic [1:0] {
    IrqRise = 2'b00,
    IrqFall = 2'b01,
    IrqHigh = 2'b10,
    IrqLow  = 2'b11
  } irq_type_e;

endpackage

// File: rtl/gpio_debounce.sv
// One pin: synchroniser chain followed by an optional run-length debounce filter.
module gpio_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_W        = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            pin_i,
  input  logic            db_en_i,
  input  logic [DB_W-1:0] db_thresh_i,
  output logic            filt_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_filt;
  logic [DB_W-1:0]        r_cnt;
  logic                   w_sync;
  logic                   w_filt_d;
  logic [DB_W-1:0]        w_cnt_d;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // >= rather than == so a threshold lowered mid-count still resolves without wrapping
  always_comb begin
    w_filt_d = r_filt;
    w_cnt_d  = '0;
    if (!db_en_i) begin
      w_filt_d = w_sync;
    end else if (w_sync != r_filt) begin
      if (r_cnt >= db_thresh_i) begin
        w_filt_d = w_sync;
      end else begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pin_i};
      r_filt <= w_filt_d;
      r_cnt  <= w_cnt_d;
    end
  end

  assign filt_o = r_filt;

endmodule

// File: rtl/gpio_irq_core.sv
// GPIO input filtering with per-pin edge/level interrupt status and a combined request.
module gpio_irq_core
  import gpio_pkg::*;
#(
  parameter int unsigned PIN_NUM     = DefaultPinNum,
  parameter int unsigned SYNC_STAGES = DefaultSyncStages,
  parameter int unsigned DB_W        = DefaultDbW
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [PIN_NUM-1:0] gpio_in_i,
  input  logic [PIN_NUM-1:0] db_en_i,
  input  logic [DB_W-1:0]    db_thresh_i,
  input  logic [PIN_NUM-1:0] inten_i,
  input  logic [PIN_NUM-1:0] inttype0_i,
  input  logic [PIN_NUM-1:0] inttype1_i,
  input  logic [PIN_NUM-1:0] stat_clr_i,
  output logic [PIN_NUM-1:0] in_o,
  output logic [PIN_NUM-1:0] stat_o,
  output logic               irq_o
);

  logic [PIN_NUM-1:0] w_filt;
  logic [PIN_NUM-1:0] r_filt_q;
  logic [PIN_NUM-1:0] r_stat;
  logic [PIN_NUM-1:0] w_rise;
  logic [PIN_NUM-1:0] w_fall;
  logic [PIN_NUM-1:0] w_event;
  logic [PIN_NUM-1:0] w_stat_d;

  for (genvar g = 0; g < PIN_NUM; g++) begin : gen_pin
    gpio_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_W       (DB_W)
    ) u_debounce (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .pin_i      (gpio_in_i[g]),
      .db_en_i    (db_en_i[g]),
      .db_thresh_i(db_thresh_i),
      .filt_o     (w_filt[g])
    );
  end

  assign w_rise = w_filt & ~r_filt_q;
  assign w_fall = ~w_filt & r_filt_q;

  always_comb begin
    w_event = '0;
    for (int n = 0; n < PIN_NUM; n++) begin
      unique case (irq_type_e'({inttype1_i[n], inttype0_i[n]}))
        IrqRise: w_event[n] = w_rise[n];
        IrqFall: w_event[n] = w_fall[n];
        IrqHigh: w_event[n] = w_filt[n];
        IrqLow:  w_event[n] = ~w_filt[n];
        default: w_event[n] = 1'b0;
      endcase
    end
  end

  // Set wins over a simultaneous clear
  assign w_stat_d = (r_stat & ~stat_clr_i) | (w_event & inten_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_filt_q <= '0;
      r_stat   <= '0;
    end else begin
      r_filt_q <= w_filt;
      r_stat   <= w_stat_d;
    end
  end

  assign in_o   = w_filt;
  assign stat_o = r_stat;
  assign irq_o  = |(r_stat & inten_i);

endmodule

// File: tb/tb_gpio_irq_core.sv
// Scoreboard bench: a run-length reference model queues expected outputs, a monitor compares.
module tb_gpio_irq_core;

  localparam int P = 8;
  localparam int S = 2;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [P-1:0] gpio, db_en, inten, t0, t1, clr;
  logic [W-1:0] thresh;
  logic [P-1:0] in_o, stat_o;
  logic         irq_o;

  always #5 clk = ~clk;

  gpio_irq_core #(
    .PIN_NUM    (P),
    .SYNC_STAGES(S),
    .DB_W       (W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .gpio_in_i  (gpio),
    .db_en_i    (db_en),
    .db_thresh_i(thresh),
    .inten_i    (inten),
    .inttype0_i (t0),
    .inttype1_i (t1),
    .stat_clr_i (clr),
    .in_o       (in_o),
    .stat_o     (stat_o),
    .irq_o      (irq_o)
  );

  typedef struct {
    logic [P-1:0] in_v;
    logic [P-1:0] stat;
    logic         irq;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state: pad history, accepted level, previous level, status, run lengths
  logic [P-1:0] m_hist [S];
  logic [P-1:0] m_filt, m_prev, m_stat;
  int           m_run [P];

  task automatic model_step();
    logic [P-1:0] sync, nf, ev;
    exp_t e;
    if (rst) begin
      for (int i = 0; i < S; i++) m_hist[i] = '0;
      m_filt = '0;
      m_prev = '0;
      m_stat = '0;
      for (int n = 0; n < P; n++) m_run[n] = 0;
    end else begin
      sync = m_hist[S-1];
      for (int n = 0; n < P; n++) begin
        case ({t1[n], t0[n]})
          2'd0:    ev[n] = m_filt[n] && !m_prev[n];
          2'd1:    ev[n] = !m_filt[n] && m_prev[n];
          2'd2:    ev[n] = m_filt[n];
          default: ev[n] = !m_filt[n];
        endcase
      end
      // Level accepted once it has differed for thresh+1 consecutive cycles
      nf = m_filt;
      for (int n = 0; n < P; n++) begin
        if (!db_en[n]) begin
          nf[n] = sync[n];
          m_run[n] = 0;
        end else if (sync[n] == m_filt[n]) begin
          m_run[n] = 0;
        end else begin
          m_run[n] = m_run[n] + 1;
          if (m_run[n] >= int'(thresh) + 1) begin
            nf[n] = sync[n];
            m_run[n] = 0;
          end
        end
      end
      m_stat = (m_stat & ~clr) | (ev & inten);
      for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = gpio;
      m_prev = m_filt;
      m_filt = nf;
    end
    e.in_v = m_filt;
    e.stat = m_stat;
    e.irq  = |(m_stat & inten);
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string name, input int c, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, c, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("in_o", e.cyc, 32'(in_o), 32'(e.in_v));
        check("stat_o", e.cyc, 32'(stat_o), 32'(e.stat));
        check("irq_o", e.cyc, 32'(irq_o), 32'(e.irq));
      end
    end
  end

  initial begin : driver
    logic [P-1:0] tgl;
    rst = 1'b1; gpio = '0; db_en = '0; inten = '0; t0 = '0; t1 = '0; clr = '0; thresh = '0;
    @(negedge clk);
    tick(3);
    rst = 1'b0;

    // Rising edge on pin 0, then clear
    inten[0] = 1'b1;
    gpio[0] = 1'b1;
    tick(5);
    clr[0] = 1'b1; tick(1); clr = '0;
    tick(2);

    // Debounce on pin 1: 3-cycle glitch rejected, 4-cycle level accepted
    db_en[1] = 1'b1; thresh = 4'd3;
    gpio[1] = 1'b1; tick(3);
    gpio[1] = 1'b0; tick(6);
    gpio[1] = 1'b1; tick(8);

    // High level on pin 2: clear ineffective while high
    t1[2] = 1'b1; inten[2] = 1'b1;
    gpio[2] = 1'b1; tick(6);
    clr[2] = 1'b1; tick(1); clr = '0;
    tick(3);
    gpio[2] = 1'b0; tick(4);
    clr[2] = 1'b1; tick(1); clr = '0;
    tick(2);

    // Falling event coincident with clear on pin 3
    t0[3] = 1'b1; inten[3] = 1'b1;
    gpio[3] = 1'b1; tick(5);
    gpio[3] = 1'b0; tick(3);
    clr[3] = 1'b1; tick(1); clr = '0;
    tick(2);

    // Edges with interrupts disabled, then status held after inten drops
    for (int i = 0; i < 4; i++) begin
      gpio[4] = ~gpio[4]; tick(4);
    end
    inten[4] = 1'b1;
    gpio[4] = 1'b0; tick(4);
    gpio[4] = 1'b1; tick(5);
    inten[4] = 1'b0; tick(3);

    // Reset mid-debounce with pin 5 held high across release
    db_en[5] = 1'b1; thresh = 4'd5; inten[5] = 1'b1;
    gpio[5] = 1'b1; tick(4);
    rst = 1'b1; tick(2);
    rst = 1'b0; tick(12);

    // Maximum threshold on pin 6
    db_en[6] = 1'b1; thresh = 4'hf; inten[6] = 1'b1;
    gpio[6] = 1'b1; tick(20);

    // Random phase
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) begin
        db_en  = P'($urandom);
        inten  = P'($urandom);
        t0     = P'($urandom);
        t1     = P'($urandom);
        thresh = ($urandom_range(0, 7) == 0) ? 4'hf : W'($urandom_range(0, 4));
      end
      tgl  = P'($urandom & $urandom & $urandom);
      gpio = gpio ^ tgl;
      clr  = P'($urandom & $urandom & $urandom & $urandom);
      rst  = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    rst = 1'b0; clr = '0;
    tick(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
